// File: rtl/ctrl_seq_pkg.sv
// Shared opcode, FSM-state and decode-bundle definitions for the instruction sequencer.
// Combinational only; no latency, no backpressure.
package ctrl_seq_pkg;

    localparam int OP_MSB = 8;
    localparam int OP_LSB = 4;
    localparam int RS_MSB = 3;
    localparam int RT_MSB = 1;

    typedef enum logic [4:0] {
        OP_NOP  = 5'd0,
        OP_ADD  = 5'd1,
        OP_ADDC = 5'd2,
        OP_SUB  = 5'd3,
        OP_SUBC = 5'd4,
        OP_LSL  = 5'd5,
        OP_LSLC = 5'd6,
        OP_LSR  = 5'd7,
        OP_LSRC = 5'd8,
        OP_ASR  = 5'd9,
        OP_NEG  = 5'd10,
        OP_AND  = 5'd11,
        OP_OR   = 5'd12,
        OP_CMP  = 5'd13,
        OP_IMME = 5'd14,
        OP_BLT  = 5'd15,
        OP_BNE  = 5'd16,
        OP_LW   = 5'd17,
        OP_SW   = 5'd18,
        OP_ALW  = 5'd19,
        OP_ASW  = 5'd20,
        OP_HALT = 5'd21
    } op_code;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_WB2,
        S_HALTED
    } ctrl_state;

    typedef struct packed {
        logic is_alu;
        logic writes_rf;
        logic is_branch;
        logic is_mem;
        logic is_store;
        logic autoinc;
        logic uses_carry;
    } ctrl_t;

endpackage

// File: rtl/ctrl_seq_decode.sv
// Opcode to control-bundle decoder for the sequencer.
// Purely combinational; no backpressure.
module ctrl_decode
    import ctrl_seq_pkg::*;
(
    input  op_code op_i,
    output ctrl_t  ctl_o
);

    always_comb begin
        ctl_o = '0;
        case (op_i)
            OP_ADD, OP_SUB, OP_LSL, OP_LSR, OP_ASR, OP_NEG, OP_AND, OP_OR: begin
                ctl_o.is_alu    = 1'b1;
                ctl_o.writes_rf = 1'b1;
            end
            OP_ADDC, OP_SUBC, OP_LSLC, OP_LSRC: begin
                ctl_o.is_alu     = 1'b1;
                ctl_o.writes_rf  = 1'b1;
                ctl_o.uses_carry = 1'b1;
            end
            OP_IMME: ctl_o.writes_rf = 1'b1;
            OP_BLT, OP_BNE: ctl_o.is_branch = 1'b1;
            OP_LW: ctl_o.is_mem = 1'b1;
            OP_SW: begin
                ctl_o.is_mem   = 1'b1;
                ctl_o.is_store = 1'b1;
            end
            OP_ALW: begin
                ctl_o.is_mem  = 1'b1;
                ctl_o.autoinc = 1'b1;
            end
            OP_ASW: begin
                ctl_o.is_mem   = 1'b1;
                ctl_o.is_store = 1'b1;
                ctl_o.autoinc  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC (3 cycles), loads/stores 5, auto-increment 6.
// No backpressure; strobes are suppressed combinationally while reset is high.
module ctrl_seq
    import ctrl_seq_pkg::*;
#(
    parameter int PC_W = 8,
    parameter int DW   = 8
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            start_i,
    output logic            done_o,
    output logic [PC_W-1:0] imem_addr_o,
    input  logic [8:0]      instr_i,
    output logic [1:0]      rf_ra_o,
    output logic [1:0]      rf_rb_o,
    input  logic [DW-1:0]   rf_a_i,
    input  logic [DW-1:0]   rf_b_i,
    output logic [1:0]      rf_wa_o,
    output logic [DW-1:0]   rf_wd_o,
    output logic            rf_we_o,
    output op_code          alu_op_o,
    output logic [DW-1:0]   alu_a_o,
    output logic [DW-1:0]   alu_b_o,
    input  logic [DW-1:0]   alu_result_i,
    input  logic [DW-1:0]   alu_cmp_i,
    input  logic            alu_carry_i,
    output logic            flag_c_o,
    output logic            flag_n_o,
    output logic            flag_z_o,
    output logic [DW-1:0]   dmem_addr_o,
    output logic [DW-1:0]   dmem_wd_o,
    output logic            dmem_we_o,
    input  logic [DW-1:0]   dmem_rd_i
);

    ctrl_state       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, pc_inc;
    logic [8:0]      ir_q, ir_d;
    logic            c_q, c_d, n_q, n_d, z_q, z_d;
    logic            rf_we_raw, dmem_we_raw, br_taken;
    op_code          op;
    logic [1:0]      rs, rt;
    ctrl_t           ctl;

    assign op       = op_code'(ir_q[OP_MSB:OP_LSB]);
    assign rs       = ir_q[RS_MSB -: 2];
    assign rt       = ir_q[RT_MSB -: 2];
    assign pc_inc   = pc_q + PC_W'(1);
    assign br_taken = (op == OP_BLT) ? n_q : ~z_q;

    ctrl_decode u_dec (
        .op_i  (op),
        .ctl_o (ctl)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        c_d         = c_q;
        n_d         = n_q;
        z_d         = z_q;
        rf_ra_o     = '0;
        rf_rb_o     = '0;
        rf_wa_o     = '0;
        rf_wd_o     = '0;
        rf_we_raw   = 1'b0;
        alu_op_o    = OP_NOP;
        alu_a_o     = '0;
        alu_b_o     = '0;
        dmem_addr_o = '0;
        dmem_wd_o   = '0;
        dmem_we_raw = 1'b0;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start_i) begin
                    pc_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                ir_d    = instr_i;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                rf_ra_o  = rs;
                rf_rb_o  = rt;
                alu_op_o = op;
                alu_a_o  = rf_a_i;
                // Carry-chaining ops take the C flag as operand when rt selects r3.
                alu_b_o  = (ctl.uses_carry && rt == 2'd3) ? {{(DW-1){1'b0}}, c_q} : rf_b_i;
                pc_d     = pc_inc;
                state_d  = S_FETCH;
                if (ctl.writes_rf) begin
                    rf_we_raw = 1'b1;
                    rf_wa_o   = ctl.is_alu ? rs : 2'd0;
                    rf_wd_o   = ctl.is_alu ? alu_result_i : {{(DW-4){1'b0}}, ir_q[3:0]};
                end
                if (ctl.is_alu) begin
                    c_d = alu_carry_i;
                    n_d = alu_result_i[DW-1];
                    z_d = (alu_result_i == '0);
                end else if (op == OP_CMP) begin
                    n_d = alu_cmp_i[DW-1];
                    z_d = (alu_cmp_i == '0);
                end else if (ctl.is_branch) begin
                    if (br_taken) pc_d = PC_W'(rf_a_i);
                end else if (ctl.is_mem) begin
                    pc_d    = pc_q;
                    state_d = S_MEM;
                end else if (op == OP_HALT) begin
                    pc_d    = pc_q;
                    state_d = S_HALTED;
                end
            end
            S_MEM: begin
                rf_ra_o     = rs;
                rf_rb_o     = rt;
                dmem_addr_o = rf_a_i;
                if (ctl.is_store) begin
                    dmem_we_raw = 1'b1;
                    dmem_wd_o   = rf_b_i;
                end
                state_d = S_WB;
            end
            S_WB: begin
                rf_ra_o = rs;
                rf_rb_o = rt;
                if (!ctl.is_store) begin
                    rf_we_raw = 1'b1;
                    rf_wa_o   = rt;
                    rf_wd_o   = dmem_rd_i;
                end
                if (ctl.autoinc) begin
                    state_d = S_WB2;
                end else begin
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_WB2: begin
                // rs is read here, after any load into rt has landed.
                rf_ra_o   = rs;
                rf_we_raw = 1'b1;
                rf_wa_o   = rs;
                rf_wd_o   = rf_a_i + DW'(1);
                pc_d      = pc_inc;
                state_d   = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            c_q     <= 1'b0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            c_q     <= c_d;
            n_q     <= n_d;
            z_q     <= z_d;
        end
    end

    assign rf_we_o     = rf_we_raw & ~reset;
    assign dmem_we_o   = dmem_we_raw & ~reset;
    assign done_o      = (state_q == S_HALTED);
    assign imem_addr_o = pc_q;
    assign flag_c_o    = c_q;
    assign flag_n_o    = n_q;
    assign flag_z_o    = z_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: ROM/regfile/data-memory/ALU environment plus an instruction-level reference model.
module tb_ctrl_seq;
    import ctrl_seq_pkg::*;

    logic       clk;
    logic       reset, start_i, done_o;
    logic [7:0] imem_addr_o;
    logic [8:0] instr_i;
    logic [1:0] rf_ra_o, rf_rb_o, rf_wa_o;
    logic [7:0] rf_a_i, rf_b_i, rf_wd_o;
    logic       rf_we_o;
    op_code     alu_op_o;
    logic [7:0] alu_a_o, alu_b_o, alu_result_i, alu_cmp_i;
    logic       alu_carry_i;
    logic       flag_c_o, flag_n_o, flag_z_o;
    logic [7:0] dmem_addr_o, dmem_wd_o, dmem_rd_i;
    logic       dmem_we_o;

    ctrl_seq #(.PC_W(8), .DW(8)) dut (
        .CLK(clk), .reset(reset), .start_i(start_i), .done_o(done_o),
        .imem_addr_o(imem_addr_o), .instr_i(instr_i),
        .rf_ra_o(rf_ra_o), .rf_rb_o(rf_rb_o), .rf_a_i(rf_a_i), .rf_b_i(rf_b_i),
        .rf_wa_o(rf_wa_o), .rf_wd_o(rf_wd_o), .rf_we_o(rf_we_o),
        .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
        .alu_result_i(alu_result_i), .alu_cmp_i(alu_cmp_i), .alu_carry_i(alu_carry_i),
        .flag_c_o(flag_c_o), .flag_n_o(flag_n_o), .flag_z_o(flag_z_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wd_o(dmem_wd_o), .dmem_we_o(dmem_we_o),
        .dmem_rd_i(dmem_rd_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment state (rf, dm) and reference-model state (mrf, mdm, mpc, flags).
    logic [8:0] rom [256];
    logic [7:0] rf  [4];
    logic [7:0] dm  [256];
    logic [7:0] mrf [4];
    logic [7:0] mdm [256];
    logic [7:0] mpc;
    logic       mc, mn, mz;
    logic       sync_en;
    int         n_chk, n_pass;

    // External ALU: returns {cmp, carry, result}.
    function automatic logic [16:0] alu_fn(input op_code op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        case (op)
            OP_ADD, OP_ADDC: s = {1'b0, a} + {1'b0, b};
            OP_SUB, OP_SUBC: s = {1'b0, a} - {1'b0, b};
            OP_LSL, OP_LSLC: s = {a, b[0]};
            OP_LSR, OP_LSRC: s = {a[0], b[0], a[7:1]};
            OP_ASR:          s = {a[0], a[7], a[7:1]};
            OP_NEG:          s = 9'd0 - {1'b0, a};
            OP_AND:          s = {1'b0, a & b};
            OP_OR:           s = {1'b0, a | b};
            default:         s = 9'd0;
        endcase
        return {a - b, s};
    endfunction

    always_comb {alu_cmp_i, alu_carry_i, alu_result_i} = alu_fn(alu_op_o, alu_a_o, alu_b_o);
    assign rf_a_i = rf[rf_ra_o];
    assign rf_b_i = rf[rf_rb_o];

    always @(posedge clk) begin
        instr_i   <= rom[imem_addr_o];
        dmem_rd_i <= dm[dmem_addr_o];
        if (sync_en) begin
            rf <= mrf;
            dm <= mdm;
        end else begin
            if (rf_we_o)   rf[rf_wa_o]     <= rf_wd_o;
            if (dmem_we_o) dm[dmem_addr_o] <= dmem_wd_o;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [8:0] mk(input op_code op, input logic [1:0] rs, input logic [1:0] rt);
        return {op, rs, rt};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = mk(OP_NOP, 2'd0, 2'd0);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        start_i = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mpc = 8'd0; mc = 1'b0; mn = 1'b0; mz = 1'b0;
    endtask

    task automatic load_env();
        sync_en = 1'b1;
        @(negedge clk);
        sync_en = 1'b0;
    endtask

    task automatic start_run();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        mpc = 8'd0;
        chk("start_done", 32'(done_o), 32'd0);
        chk("start_pc", 32'(imem_addr_o), 32'd0);
    endtask

    // Called at the negedge of an instruction's FETCH cycle; returns at the next FETCH (or HALTED).
    task automatic run_instr(output bit halted);
        logic [8:0]  ins;
        op_code      op;
        logic [1:0]  rs, rt;
        logic [7:0]  a, b, r;
        logic [16:0] alu;
        int lat, exp_we, exp_dwe, we_at, dwe_at;
        int n_we, n_dwe, n_both, n_done, first_we, first_dwe;
        ins = rom[mpc];
        op  = op_code'(ins[8:4]);
        rs  = ins[3:2];
        rt  = ins[1:0];
        a   = mrf[rs];
        b   = mrf[rt];
        lat = 3; exp_we = 0; exp_dwe = 0; we_at = -1; dwe_at = -1; halted = 1'b0;
        chk("pc", 32'(imem_addr_o), 32'(mpc));
        if (op inside {OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_LSL, OP_LSLC, OP_LSR, OP_LSRC,
                       OP_ASR, OP_NEG, OP_AND, OP_OR}) begin
            if (op inside {OP_ADDC, OP_SUBC, OP_LSLC, OP_LSRC} && rt == 2'd3) b = {7'd0, mc};
            alu = alu_fn(op, a, b);
            mrf[rs] = alu[7:0];
            mc = alu[8]; mn = alu[7]; mz = (alu[7:0] == 8'd0);
            exp_we = 1; we_at = 2;
            mpc = mpc + 8'd1;
        end else begin
            case (op)
                OP_CMP:  begin r = a - b; mn = r[7]; mz = (r == 8'd0); mpc = mpc + 8'd1; end
                OP_IMME: begin mrf[0] = {4'd0, ins[3:0]}; exp_we = 1; we_at = 2; mpc = mpc + 8'd1; end
                OP_BLT:  mpc = mn ? a : mpc + 8'd1;
                OP_BNE:  mpc = !mz ? a : mpc + 8'd1;
                OP_LW:   begin lat = 5; mrf[rt] = mdm[a]; exp_we = 1; we_at = 4; mpc = mpc + 8'd1; end
                OP_SW:   begin lat = 5; mdm[a] = b; exp_dwe = 1; dwe_at = 3; mpc = mpc + 8'd1; end
                OP_ALW:  begin
                    lat = 6; mrf[rt] = mdm[a]; mrf[rs] = mrf[rs] + 8'd1;
                    exp_we = 2; we_at = 4; mpc = mpc + 8'd1;
                end
                OP_ASW:  begin
                    lat = 6; mdm[a] = b; mrf[rs] = a + 8'd1;
                    exp_we = 1; we_at = 5; exp_dwe = 1; dwe_at = 3; mpc = mpc + 8'd1;
                end
                OP_HALT: halted = 1'b1;
                default: mpc = mpc + 8'd1;
            endcase
        end
        n_we = 0; n_dwe = 0; n_both = 0; n_done = 0; first_we = -1; first_dwe = -1;
        for (int k = 0; k < lat; k++) begin
            // start_i noise mid-instruction must be ignored.
            start_i = ($urandom_range(0, 3) == 0);
            if (rf_we_o) begin n_we++; if (first_we < 0) first_we = k; end
            if (dmem_we_o) begin n_dwe++; if (first_dwe < 0) first_dwe = k; end
            if (rf_we_o && dmem_we_o) n_both++;
            if (done_o) n_done++;
            @(negedge clk);
        end
        start_i = 1'b0;
        chk("rf_we_count", 32'(n_we), 32'(exp_we));
        chk("dmem_we_count", 32'(n_dwe), 32'(exp_dwe));
        chk("we_overlap", 32'(n_both), 32'd0);
        chk("done_busy", 32'(n_done), 32'd0);
        if (exp_we > 0)  chk("rf_we_cycle", 32'(first_we), 32'(we_at));
        if (exp_dwe > 0) begin
            chk("dmem_we_cycle", 32'(first_dwe), 32'(dwe_at));
            chk("dmem_data", 32'(dm[a]), 32'(mdm[a]));
        end
        chk("regs", {rf[3], rf[2], rf[1], rf[0]}, {mrf[3], mrf[2], mrf[1], mrf[0]});
        chk("flags", 32'({flag_c_o, flag_n_o, flag_z_o}), 32'({mc, mn, mz}));
        if (halted) begin
            chk("halt_done", 32'(done_o), 32'd1);
            chk("halt_pc", 32'(imem_addr_o), 32'(mpc));
        end
    endtask

    task automatic run_prog(input int max_instr);
        bit h;
        h = 1'b0;
        for (int i = 0; i < max_instr && !h; i++) run_instr(h);
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        sync_en = 1'b0; reset = 1'b1; start_i = 1'b0;
        for (int i = 0; i < 4; i++) mrf[i] = 8'd0;
        for (int i = 0; i < 256; i++) mdm[i] = 8'd0;
        clear_rom();
        do_reset();
        chk("reset_outputs", 32'({done_o, flag_c_o, flag_n_o, flag_z_o, rf_we_o, dmem_we_o}), 32'd0);
        chk("reset_pc", 32'(imem_addr_o), 32'd0);

        // IMME 5 then HALT.
        load_env();
        rom[0] = mk(OP_IMME, 2'd1, 2'd1);
        rom[1] = mk(OP_HALT, 2'd0, 2'd0);
        start_run();
        run_prog(4);

        // ADD with carry out, then ADDC consuming it (restart from HALTED).
        clear_rom();
        mrf[0] = 8'd0; mrf[1] = 8'd200; mrf[2] = 8'd100; mrf[3] = 8'd0;
        load_env();
        rom[0] = mk(OP_ADD,  2'd1, 2'd2);
        rom[1] = mk(OP_ADDC, 2'd0, 2'd3);
        rom[2] = mk(OP_HALT, 2'd0, 2'd0);
        start_run();
        run_prog(4);

        // CMP, taken BLT, equal CMP, untaken BNE.
        clear_rom();
        mrf[0] = 8'd0; mrf[1] = 8'd3; mrf[2] = 8'd7; mrf[3] = 8'd10;
        load_env();
        rom[0]  = mk(OP_CMP,  2'd1, 2'd2);
        rom[1]  = mk(OP_BLT,  2'd3, 2'd0);
        rom[10] = mk(OP_CMP,  2'd0, 2'd0);
        rom[11] = mk(OP_BNE,  2'd3, 2'd0);
        rom[12] = mk(OP_HALT, 2'd0, 2'd0);
        start_run();
        run_prog(8);

        // Store then auto-increment load of the same location.
        clear_rom();
        mrf[0] = 8'h20; mrf[1] = 8'hAB; mrf[2] = 8'd0;
        load_env();
        rom[0] = mk(OP_SW,   2'd0, 2'd1);
        rom[1] = mk(OP_ALW,  2'd0, 2'd2);
        rom[2] = mk(OP_HALT, 2'd0, 2'd0);
        start_run();
        run_prog(4);

        // Reset asserted during MEM of a store.
        clear_rom();
        mrf[0] = 8'h30; mrf[1] = 8'd3; mrf[2] = 8'd7;
        mdm[8'h30] = 8'h55;
        load_env();
        rom[0] = mk(OP_CMP, 2'd1, 2'd2);
        rom[1] = mk(OP_SW,  2'd0, 2'd1);
        start_run();
        run_prog(1);
        repeat (3) @(negedge clk);
        chk("mem_we_before_reset", 32'(dmem_we_o), 32'd1);
        reset = 1'b1;
        #1;
        chk("mem_we_in_reset", 32'(dmem_we_o), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        mpc = 8'd0; mc = 1'b0; mn = 1'b0; mz = 1'b0;
        chk("post_reset_state", 32'({done_o, flag_c_o, flag_n_o, flag_z_o, imem_addr_o}), 32'd0);
        chk("post_reset_dmem", 32'(dm[8'h30]), 32'h55);
        @(negedge clk);
        chk("idle_holds", 32'({done_o, rf_we_o, dmem_we_o, imem_addr_o}), 32'd0);

        // Random programs, restarting whenever HALT is reached.
        for (int i = 0; i < 256; i++) begin
            logic [4:0] opv;
            opv = 5'($urandom_range(0, 22));
            if (opv == 5'd21 && $urandom_range(0, 4) != 0) opv = 5'd13;
            rom[i] = {opv, 4'($urandom)};
            mdm[i] = 8'($urandom);
        end
        for (int i = 0; i < 4; i++) mrf[i] = 8'($urandom);
        do_reset();
        load_env();
        start_run();
        for (int i = 0; i < 600; i++) begin
            bit h;
            run_instr(h);
            if (h) start_run();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
